// File: rtl/audio_tone_if.sv
// Control-unit side of the tone player: load/play strobes, the data word and the status it reads back.
interface audio_tone_if;
  logic       audioreg;
  logic       audioact;
  logic [7:0] data_in;
  logic       speaker;
  logic       busy;
  logic       done;

  modport master (output audioreg, audioact, data_in, input speaker, busy, done);
  modport slave  (input audioreg, audioact, data_in, output speaker, busy, done);
endinterface

// File: rtl/audio_tone_player.sv
// Square-wave tone generator: plays a latched note/duration word on the speaker pin,
// flagging busy while it plays and pulsing done when a tone runs to completion.
module audio_tone_player #(
  parameter int BASE_DIV    = 3125,
  parameter int TICK_CYCLES = 3125000,
  parameter int DW          = 8
) (
  input logic         clk,
  input logic         reset,
  audio_tone_if.slave bus
);

  // Sized for note 0 (16 units) so a rest never truncates its reload value.
  localparam int HW = (16 * BASE_DIV > 1) ? $clog2(16 * BASE_DIV) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_M1 = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   audio_reg, audio_reg_next;
  logic            act_q_reg, act_q_next;
  logic [HW-1:0]   half_reg, half_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [3:0]      dur_reg, dur_next;
  logic [3:0]      note_reg, note_next;
  logic            speaker_reg, speaker_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  logic            start;
  logic [DW-1:0]   play_word;

  function automatic logic [HW-1:0] hp_m1(input logic [3:0] note);
    logic [31:0] v;
    v = 32'(BASE_DIV) * (32'd16 - {28'd0, note}) - 32'd1;
    return v[HW-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      audio_reg   <= '0;
      act_q_reg   <= 1'b0;
      half_reg    <= '0;
      tick_reg    <= '0;
      dur_reg     <= '0;
      note_reg    <= '0;
      speaker_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      audio_reg   <= audio_reg_next;
      act_q_reg   <= act_q_next;
      half_reg    <= half_next;
      tick_reg    <= tick_next;
      dur_reg     <= dur_next;
      note_reg    <= note_next;
      speaker_reg <= speaker_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    half_next      = half_reg;
    tick_next      = tick_reg;
    dur_next       = dur_reg;
    note_next      = note_reg;
    speaker_next   = speaker_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    act_q_next     = bus.audioact;
    audio_reg_next = bus.audioreg ? bus.data_in : audio_reg;

    start     = bus.audioact & ~act_q_reg;
    // Same-cycle load and play uses the incoming word rather than the stale register.
    play_word = bus.audioreg ? bus.data_in : audio_reg;

    if (start) begin
      // Fresh start and retrigger are identical: everything reloads, busy holds high.
      state_next   = PLAY;
      busy_next    = 1'b1;
      speaker_next = 1'b0;
      note_next    = play_word[7:4];
      dur_next     = play_word[3:0];
      half_next    = hp_m1(play_word[7:4]);
      tick_next    = TICK_M1;
    end else begin
      case (state_reg)
        PLAY: begin
          if (half_reg == '0) begin
            half_next = hp_m1(note_reg);
            if (note_reg != 4'd0) speaker_next = ~speaker_reg;
          end else begin
            half_next = half_reg - 1'b1;
          end

          if (tick_reg == '0) begin
            tick_next = TICK_M1;
            if (dur_reg == 4'd0) begin
              state_next   = DONE;
              busy_next    = 1'b0;
              speaker_next = 1'b0;
              done_next    = 1'b1;
            end else begin
              dur_next = dur_reg - 1'b1;
            end
          end else begin
            tick_next = tick_reg - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.speaker = speaker_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_audio_tone_player.sv
// Randomized and directed bench for audio_tone_player; outputs are predicted from the
// elapsed time since the most recent start, not from a cycle-by-cycle state machine.
module tb_audio_tone_player;
  localparam int BD = 2;
  localparam int TC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_tone_if bus();

  audio_tone_player #(.BASE_DIV(BD), .TICK_CYCLES(TC), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: last start time plus the word it latched.
  bit       m_active;
  int       m_t0;
  int       m_note;
  int       m_dur;
  bit [7:0] m_areg;
  bit       m_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_areg   = 8'h00;
    m_prev   = 1'b0;
  endtask

  task automatic model_edge();
    bit       start;
    bit [7:0] word;
    if (reset) begin
      model_clear();
      return;
    end
    start = bus.audioact && !m_prev;
    word  = bus.audioreg ? bus.data_in : m_areg;
    if (start) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_note   = int'(word[7:4]);
      m_dur    = int'(word[3:0]);
      $display("cycle %0d: start word=%02h hp=%0d busy_cycles=%0d", cyc, word,
               BD * (16 - m_note), (m_dur + 1) * TC);
    end
    if (bus.audioreg) m_areg = bus.data_in;
    m_prev = bus.audioact;
  endtask

  task automatic check_outputs();
    int e, total, hp;
    logic exp_busy, exp_done, exp_spk;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_spk  = 1'b0;
    if (m_active) begin
      e     = cyc - m_t0;
      total = (m_dur + 1) * TC;
      hp    = BD * (16 - m_note);
      exp_busy = (e < total);
      exp_done = (e == total);
      exp_spk  = exp_busy && (m_note != 0) && (((e / hp) % 2) == 1);
    end
    check_eq("busy", 32'(bus.busy), 32'(exp_busy));
    check_eq("done", 32'(bus.done), 32'(exp_done));
    check_eq("speaker", 32'(bus.speaker), 32'(exp_spk));
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic set_in(input bit r, input bit a, input bit [7:0] d);
    bus.audioreg = r;
    bus.audioact = a;
    bus.data_in  = d;
  endtask

  // Reset lands between edges, so the outputs must drop without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_speaker", 32'(bus.speaker), 32'd0);
    tick_cycle();
    reset = 1'b0;
  endtask

  task automatic play(input bit [7:0] w);
    set_in(1'b1, 1'b0, w);
    run(1);
    set_in(1'b0, 1'b1, 8'h00);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bit act;
    set_in(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    model_clear();
    run(3);
    reset = 1'b0;
    run(2);

    // Basic tone: 20 busy cycles, hp = 2.
    play(8'hF1);
    run(25);

    // Reset mid-tone, then a fresh tone.
    play(8'hF1);
    run(6);
    async_reset();
    run(2);
    play(8'hF1);
    run(25);

    // Rest: 40 cycles of silence with a normal done.
    play(8'h03);
    run(45);

    // Same-cycle load and play, then replay of the bypassed word.
    set_in(1'b1, 1'b0, 8'h11);
    run(1);
    set_in(1'b1, 1'b1, 8'hE0);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(14);
    set_in(1'b0, 1'b1, 8'h00);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(14);

    // Held strobe gives a single tone, then a retrigger mid-play.
    set_in(1'b1, 1'b0, 8'hF1);
    run(1);
    set_in(1'b0, 1'b1, 8'h00);
    run(60);
    set_in(1'b0, 1'b0, 8'h00);
    run(2);
    play(8'hF1);
    run(3);
    set_in(1'b1, 1'b0, 8'hE1);
    run(1);
    set_in(1'b0, 1'b1, 8'h00);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(30);

    // Load during play leaves the tone alone; the next play uses the new word.
    play(8'hF1);
    run(2);
    set_in(1'b1, 1'b0, 8'h20);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(20);
    set_in(1'b0, 1'b1, 8'h00);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(14);

    // Start landing exactly on the done cycle.
    play(8'hF1);
    run(19);
    set_in(1'b0, 1'b1, 8'h00);
    run(1);
    set_in(1'b0, 1'b0, 8'h00);
    run(24);

    // Random strobes, words and occasional resets.
    act = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (act) act = ($urandom_range(0, 2) != 0);
      else     act = ($urandom_range(0, 11) == 0);
      set_in(($urandom_range(0, 3) == 0), act, 8'($urandom));
      if ($urandom_range(0, 149) == 0) async_reset();
      run(1 + $urandom_range(0, 7));
    end
    set_in(1'b0, 1'b0, 8'h00);
    run(170);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
